// File: rtl/audio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_ctrl_pkg
//  Description : Shared transport state encoding, button priority constants
//                and the command resolver used by audio_transport_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RECORD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_PLAY   = 2'd1,
        CMD_RECORD = 2'd2,
        CMD_STOP   = 2'd3
    } cmd_e;

    // Bit positions in the press vector; a higher index wins.
    localparam int unsigned PRIO_PLAY   = 0;
    localparam int unsigned PRIO_RECORD = 1;
    localparam int unsigned PRIO_STOP   = 2;

    function automatic cmd_e resolve_cmd(input logic [2:0] presses);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (presses[PRIO_STOP])
            cmd = CMD_STOP;
        else if (presses[PRIO_RECORD])
            cmd = CMD_RECORD;
        else if (presses[PRIO_PLAY])
            cmd = CMD_PLAY;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchronizer, stable-count debouncer and a one-cycle
//                press strobe on each accepted rising level.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
    import audio_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only advances while the synchronized input disagrees with the
    // accepted level; any agreeing sample restarts it.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/audio_transport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : audio_transport_ctrl
//  Description : Multi-track record/play transport with debounced buttons,
//                per-track take lengths and memory address/strobe generation.
//                Define AUDIO_LOOP_EN to make playback loop continuously.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_transport_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int NUM_TRACKS      = 4,
    parameter int ADDR_W          = 14,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TRK_W           = $clog2(NUM_TRACKS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    play_i,
    input  logic                    record_i,
    input  logic                    stop_i,
    input  logic [TRK_W-1:0]        track_sel_i,
    input  logic                    sample_tick_i,
    output logic                    start_play_o,
    output logic                    start_record_o,
    output logic                    playing_o,
    output logic                    recording_o,
    output logic [TRK_W+ADDR_W-1:0] mem_addr_o,
    output logic                    read_en_o,
    output logic                    write_en_o,
    output logic                    done_o
);

    localparam logic [ADDR_W:0]   FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [2:0] presses;
    cmd_e       cmd;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(play_i),   .press_o(presses[PRIO_PLAY])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_record (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(record_i), .press_o(presses[PRIO_RECORD])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk_i(clk_i), .rst_i(rst_i), .btn_i(stop_i),   .press_o(presses[PRIO_STOP])
    );

    assign cmd = resolve_cmd(presses);

    state_e                  state_q;
    logic [TRK_W-1:0]        track_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W:0]         len_q [NUM_TRACKS];
    logic [TRK_W+ADDR_W-1:0] mem_addr_q;
    logic                    start_play_q, start_record_q, playing_q, recording_q;
    logic                    read_en_q, write_en_q, done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            track_q        <= '0;
            addr_q         <= '0;
            mem_addr_q     <= '0;
            start_play_q   <= 1'b0;
            start_record_q <= 1'b0;
            playing_q      <= 1'b0;
            recording_q    <= 1'b0;
            read_en_q      <= 1'b0;
            write_en_q     <= 1'b0;
            done_q         <= 1'b0;
            for (int t = 0; t < NUM_TRACKS; t++)
                len_q[t] <= '0;
        end else begin
            start_play_q   <= 1'b0;
            start_record_q <= 1'b0;
            read_en_q      <= 1'b0;
            write_en_q     <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd == CMD_RECORD) begin
                        track_q        <= track_sel_i;
                        addr_q         <= '0;
                        state_q        <= ST_RECORD;
                        recording_q    <= 1'b1;
                        start_record_q <= 1'b1;
                    end else if (cmd == CMD_PLAY) begin
                        track_q <= track_sel_i;
                        // An empty track cannot be played; stay idle silently.
                        if (len_q[track_sel_i] != '0) begin
                            addr_q       <= '0;
                            state_q      <= ST_PLAY;
                            playing_q    <= 1'b1;
                            start_play_q <= 1'b1;
                        end
                    end
                end
                ST_RECORD: begin
                    if (cmd == CMD_STOP) begin
                        len_q[track_q] <= {1'b0, addr_q};
                        addr_q         <= '0;
                        state_q        <= ST_IDLE;
                        recording_q    <= 1'b0;
                    end else if (sample_tick_i) begin
                        write_en_q <= 1'b1;
                        mem_addr_q <= {track_q, addr_q};
                        if (addr_q == LAST_ADDR) begin
                            len_q[track_q] <= FULL_LEN;
                            addr_q         <= '0;
                            done_q         <= 1'b1;
                            state_q        <= ST_IDLE;
                            recording_q    <= 1'b0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (cmd == CMD_STOP) begin
                        addr_q    <= '0;
                        state_q   <= ST_IDLE;
                        playing_q <= 1'b0;
                    end else if (sample_tick_i) begin
                        read_en_q  <= 1'b1;
                        mem_addr_q <= {track_q, addr_q};
                        if ({1'b0, addr_q} == len_q[track_q] - (ADDR_W+1)'(1)) begin
                            done_q <= 1'b1;
                            addr_q <= '0;
`ifdef AUDIO_LOOP_EN
`else
                            state_q   <= ST_IDLE;
                            playing_q <= 1'b0;
`endif
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    playing_q   <= 1'b0;
                    recording_q <= 1'b0;
                end
            endcase
        end
    end

    assign start_play_o   = start_play_q;
    assign start_record_o = start_record_q;
    assign playing_o      = playing_q;
    assign recording_o    = recording_q;
    assign mem_addr_o     = mem_addr_q;
    assign read_en_o      = read_en_q;
    assign write_en_o     = write_en_q;
    assign done_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_transport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_transport_ctrl
//  Description : Directed and randomized bench for audio_transport_ctrl with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_transport_ctrl;

    localparam int NT    = 4;
    localparam int AW    = 3;
    localparam int DB    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          play_b, rec_b, stop_b;
    logic [TW-1:0] sel;
    logic          tick;

    logic          start_play, start_record, playing, recording;
    logic [TW+AW-1:0] mem_addr;
    logic          read_en, write_en, done;

    audio_transport_ctrl #(
        .NUM_TRACKS(NT), .ADDR_W(AW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .play_i(play_b), .record_i(rec_b), .stop_i(stop_b),
        .track_sel_i(sel), .sample_tick_i(tick),
        .start_play_o(start_play), .start_record_o(start_record),
        .playing_o(playing), .recording_o(recording),
        .mem_addr_o(mem_addr), .read_en_o(read_en), .write_en_o(write_en),
        .done_o(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode;          // 0 idle, 1 play, 2 record
    int          m_trk, m_addr;
    int          m_len [NT];
    bit          e_sp, e_sr, e_rd, e_wr, e_done;
    int          e_ma;
    bit          dly1 [3], dly2 [3], lvl [3], prs [3];
    bit [DB-1:0] win [3];

    always @(posedge clk) begin
        bit raw [3];
        bit seen;
        raw[0] = play_b; raw[1] = rec_b; raw[2] = stop_b;
        if (rst) begin
            m_mode = 0; m_trk = 0; m_addr = 0; e_ma = 0;
            e_sp = 0; e_sr = 0; e_rd = 0; e_wr = 0; e_done = 0;
            for (int t = 0; t < NT; t++) m_len[t] = 0;
            for (int b = 0; b < 3; b++) begin
                dly1[b] = 0; dly2[b] = 0; lvl[b] = 0; prs[b] = 0; win[b] = '0;
            end
        end else begin
            e_sp = 0; e_sr = 0; e_rd = 0; e_wr = 0; e_done = 0;
            if (m_mode == 0) begin
                if (prs[2]) begin
                end else if (prs[1]) begin
                    m_trk = int'(sel); m_addr = 0; m_mode = 2; e_sr = 1;
                end else if (prs[0]) begin
                    m_trk = int'(sel);
                    if (m_len[m_trk] > 0) begin
                        m_addr = 0; m_mode = 1; e_sp = 1;
                    end
                end
            end else if (m_mode == 2) begin
                if (prs[2]) begin
                    m_len[m_trk] = m_addr; m_mode = 0;
                end else if (tick) begin
                    e_wr = 1; e_ma = m_trk * DEPTH + m_addr; m_addr++;
                    if (m_addr == DEPTH) begin
                        m_len[m_trk] = DEPTH; e_done = 1; m_mode = 0;
                    end
                end
            end else begin
                if (prs[2]) begin
                    m_mode = 0;
                end else if (tick) begin
                    e_rd = 1; e_ma = m_trk * DEPTH + m_addr; m_addr++;
                    if (m_addr == m_len[m_trk]) begin
                        e_done = 1;
`ifdef AUDIO_LOOP_EN
                        m_addr = 0;
`else
                        m_mode = 0;
`endif
                    end
                end
            end
            // A level is accepted once the last DB synchronized samples all differ from it.
            for (int b = 0; b < 3; b++) begin
                seen    = dly2[b];
                dly2[b] = dly1[b];
                dly1[b] = raw[b];
                prs[b]  = 0;
                win[b]  = {win[b][DB-2:0], seen};
                if (lvl[b] ? (win[b] == '0) : (win[b] == '1)) begin
                    lvl[b] = ~lvl[b];
                    prs[b] = lvl[b];
                end
            end
        end
    end

    function automatic logic [11:0] exp_vec();
        logic [4:0] ma;
        ma = 5'(e_ma);
        return {e_sp, e_sr, m_mode == 1, m_mode == 2, ma, e_rd, e_wr, e_done};
    endfunction

    wire [11:0] dut_vec = {start_play, start_record, playing, recording,
                           mem_addr, read_en, write_en, done};

    bit chk_on = 0;
    int n_sp = 0, n_done = 0, n_wr = 0, n_rd = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("outs", 32'(dut_vec), 32'(exp_vec()));
            if (start_play) n_sp++;
            if (done)       n_done++;
            if (write_en)   n_wr++;
            if (read_en)    n_rd++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       play_b = v;
            1:       rec_b  = v;
            default: stop_b = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic press(input int b, input int trk);
        @(negedge clk);
        sel = TW'(trk);
        set_btn(b, 1'b1);
        idle(DB + 4);
        set_btn(b, 1'b0);
        idle(DB + 4);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int sp0, dn0, wr0, rd0;
    int hold [3];

    initial begin
        rst = 1'b1; play_b = 0; rec_b = 0; stop_b = 0; sel = '0; tick = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(dut_vec), 32'd0);
        chk_on = 1;
        rst = 1'b0;

        // Glitchy Play on an empty track: no transition.
        sp0 = n_sp;
        play_b = 1; idle(2); play_b = 0; idle(1); play_b = 1; idle(DB + 4);
        play_b = 0; idle(DB + 4);
        settle();
        check("glitch_no_play", 32'(n_sp - sp0), 0);
        check("glitch_idle", 32'(playing), 0);

        // Record 5 samples on track 2, then stop.
        wr0 = n_wr; dn0 = n_done;
        press(1, 2);
        check("rec_started", 32'(recording), 1);
        ticks(5);
        press(2, 0);
        settle();
        check("rec5_writes", 32'(n_wr - wr0), 5);
        check("rec5_no_done", 32'(n_done - dn0), 0);
        check("rec5_stopped", 32'(recording), 0);

`ifdef AUDIO_LOOP_EN
        sp0 = n_sp; dn0 = n_done; rd0 = n_rd;
        press(0, 2);
        ticks(12);
        settle();
        check("loop_start", 32'(n_sp - sp0), 1);
        check("loop_reads", 32'(n_rd - rd0), 12);
        check("loop_done2", 32'(n_done - dn0), 2);
        check("loop_playing", 32'(playing), 1);
        press(2, 0);
`else
        sp0 = n_sp; dn0 = n_done; rd0 = n_rd;
        press(0, 2);
        ticks(5);
        settle();
        check("play_start", 32'(n_sp - sp0), 1);
        check("play_reads", 32'(n_rd - rd0), 5);
        check("play_done", 32'(n_done - dn0), 1);
        check("play_ended", 32'(playing), 0);
`endif

        // Fill track 1 completely.
        dn0 = n_done;
        press(1, 1);
        ticks(DEPTH);
        settle();
        check("full_done", 32'(n_done - dn0), 1);
        check("full_idle", 32'(recording), 0);

        // All three buttons together in IDLE: Stop wins, nothing happens.
        @(negedge clk);
        play_b = 1; rec_b = 1; stop_b = 1; sel = 2'd1;
        idle(DB + 4);
        play_b = 0; rec_b = 0; stop_b = 0;
        idle(DB + 4);
        settle();
        check("all3_no_play", 32'(playing), 0);
        check("all3_no_rec", 32'(recording), 0);

        // Reset in the middle of a take on track 3.
        dn0 = n_done;
        press(1, 3);
        ticks(3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("midrst_outs", 32'(dut_vec), 32'd0);
        check("midrst_no_done", 32'(n_done - dn0), 0);
        sp0 = n_sp;
        press(0, 3);
        settle();
        check("midrst_play_ignored", 32'(n_sp - sp0), 0);

        // Randomized buttons, ticks and occasional reset.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            tick = ($urandom_range(0, 2) == 0);
            sel  = TW'($urandom_range(0, NT - 1));
            rst  = ($urandom_range(0, 599) == 0);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    if (($urandom_range(0, 3) == 0) && (b != 2 || $urandom_range(0, 2) == 0)) begin
                        set_btn(b, 1'b1);
                        hold[b] = $urandom_range(1, DB + 4);
                    end else begin
                        set_btn(b, 1'b0);
                        hold[b] = $urandom_range(DB + 1, 6 * DB);
                    end
                end else begin
                    hold[b]--;
                end
            end
        end
        rst = 1'b0; play_b = 0; rec_b = 0; stop_b = 0; tick = 0;
        idle(3 * DB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
